turn_controller: RTL and testbench
==================================

Name: turn_controller

Overview:
- Upstream control stage of the chess clock.
- Turns player/panel buttons into per-player CE and 1 Hz IMPULSE strobes for the two players' second/minute counter chains.
- Runs the game FSM (idle, player A running, player B running, paused, game over) and counts completed moves.
- Consumes the time-out flags returned by the downstream counter chains.

Parameters:
- TICK_DIV, 100000000, CLK cycles per IMPULSE (1 s at 100 MHz); legal range 2..2^27.
- DEB_CYCLES, 1000000, consecutive stable-high cycles needed to accept a button; used only with DEBOUNCE_EN.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- CLR  in  1  synchronous, active-high reset.
- START  in  1  level button: start game.
- PAUSE  in  1  level button: pause/resume toggle.
- BTN_A  in  1  level button: player A ends move.
- BTN_B  in  1  level button: player B ends move.
- TIMEOUT_A  in  1  level: player A time exhausted (from A counter chain).
- TIMEOUT_B  in  1  level: player B time exhausted.
- CE_A  out  1  count enable for A chain.
- CE_B  out  1  count enable for B chain.
- IMPULSE_A  out  1  one-cycle second strobe for A chain.
- IMPULSE_B  out  1  one-cycle second strobe for B chain.
- ACTIVE  out  2  00 none, 01 A running, 10 B running, 11 paused.
- GAME_OVER  out  1  high in DONE.
- LOSER  out  1  0 = A flagged, 1 = B flagged; valid when GAME_OVER.
- MOVE_CNT  out  8  completed moves.

Behaviour:
- Reset is synchronous: CLR high at a rising edge forces the following state on that edge, from any state, including mid-prescale or mid-debounce.
  - FSM = IDLE; all outputs 0; prescaler = 0; saved side = A; edge registers = 0.
- Input conditioning:
  - START, PAUSE, BTN_A and BTN_B each pass through one sync flop plus a previous-value flop.
  - Event = sync & ~prev.
  - An input first sampled high at edge k produces its FSM transition at edge k+1.
  - Holding a button produces exactly one event.
- TIMEOUT_A/B are used as levels, unsynchronised (same clock domain).
- FSM states: IDLE, RUN_A, RUN_B, PAUSED, DONE.
- IDLE:
  - START event -> RUN_A (A moves first).
  - All other inputs ignored.
- RUN_A, checked in priority order:
  - TIMEOUT_A -> DONE, LOSER=0.
  - Else PAUSE event -> PAUSED, saved side = A.
  - Else BTN_A event -> RUN_B, MOVE_CNT+1.
  - BTN_B and START are ignored.
  - BTN_A and BTN_B events in the same cycle: BTN_A wins.
- RUN_B: mirror of RUN_A (TIMEOUT_B, LOSER=1, BTN_B -> RUN_A).
- PAUSED:
  - PAUSE event -> saved side's RUN state.
  - BTN_A, BTN_B, START and TIMEOUT are ignored.
- DONE: sticky; only CLR exits.
- MOVE_CNT saturates at 255.
- Outputs are registered and decoded from the state register:
  - CE_A = (state==RUN_A); CE_B = (state==RUN_B).
  - ACTIVE encodes state: IDLE and DONE give 00.
  - GAME_OVER = (state==DONE).
- Prescaler: 27-bit counter.
  - Increments each cycle in RUN_A/RUN_B.
  - Wraps TICK_DIV-1 -> 0.
  - Held in PAUSED, IDLE and DONE.
  - Cleared to 0 on IDLE->RUN_A and on every A<->B switch.
  - Not cleared on resume from pause: the fractional second is preserved.
- IMPULSE_x:
  - High for exactly one cycle when prescaler == TICK_DIV-1 and state == RUN_x.
  - First pulse TICK_DIV cycles after entering RUN_x via start or switch.
- No IMPULSE in the cycle the FSM leaves RUN_x.
  - If a switch or pause event coincides with terminal count, that pulse is suppressed.
  - TIMEOUT takes priority and also suppresses the pulse.
- IMPULSE_A and IMPULSE_B are never high simultaneously.

Optional Feature:
- Macro: TURN_CONTROLLER_DEBOUNCE_EN.
- Defined:
  - Each button path has a counter after the sync flop.
  - The debounced level goes high only after DEB_CYCLES consecutive high samples and drops on the first low sample.
  - Event = rising edge of the debounced level.
  - Transition latency = DEB_CYCLES+1 edges after first sample.
  - A glitch shorter than DEB_CYCLES produces no event.
- Undefined: DEB_CYCLES is ignored; behaviour is exactly as in Behaviour (latency 2 edges).

Test Plan:
- TICK_DIV=4. CLR, then START pulse -> ACTIVE=01, CE_A=1 two edges later; IMPULSE_A pulses every 4 cycles, first pulse 4 cycles after entry; IMPULSE_B stays 0.
- In RUN_A, hold BTN_A 10 cycles -> exactly one switch to ACTIVE=10, MOVE_CNT=1; prescaler restarts, so the first IMPULSE_B comes 4 cycles later.
- In RUN_B at prescaler=2, PAUSE -> ACTIVE=11, no pulses for 20 cycles; PAUSE again -> ACTIVE=10 and IMPULSE_B arrives after 2 cycles (fraction preserved).
- In RUN_A, assert TIMEOUT_A together with a BTN_A event -> DONE, GAME_OVER=1, LOSER=0, CE_A=0; subsequent START/PAUSE/BTN ignored; CLR -> all outputs 0.
- 300 alternating moves -> MOVE_CNT saturates at 255; BTN_A+BTN_B events in the same cycle in RUN_A -> switch to RUN_B only.
- With TURN_CONTROLLER_DEBOUNCE_EN, DEB_CYCLES=5: a 3-cycle BTN_A glitch gives no switch; a 6-cycle press switches 6 edges after first sample.

Source files
------------

// File: rtl/turn_controller.sv
// turn_controller: chess-clock game FSM turning buttons into per-player CE/IMPULSE strobes and move count.
// Optional button debounce is enabled with `define TURN_CONTROLLER_DEBOUNCE_EN (uses DEB_CYCLES).
module turn_controller #(
  parameter int TICK_DIV   = 100000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       BTN_A,
  input  logic       BTN_B,
  input  logic       TIMEOUT_A,
  input  logic       TIMEOUT_B,
  output logic       CE_A,
  output logic       CE_B,
  output logic       IMPULSE_A,
  output logic       IMPULSE_B,
  output logic [1:0] ACTIVE,
  output logic       GAME_OVER,
  output logic       LOSER,
  output logic [7:0] MOVE_CNT
);
  typedef enum logic [2:0] {IDLE, RUN_A, RUN_B, PAUSED, DONE} state_t;
  localparam logic [26:0] TC = 27'(TICK_DIV - 1);
  // button bit order: 0 START, 1 PAUSE, 2 BTN_A, 3 BTN_B
  logic [3:0] sync_q, prev_q, lvl, ev;
  always_ff @(posedge CLK) begin
    if (CLR) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {BTN_B, BTN_A, PAUSE, START};
      prev_q <= lvl;
    end
  end
`ifdef TURN_CONTROLLER_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DMAX = CW'(DEB_CYCLES - 1);
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = '0;
    lvl = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = sync_q[i] ? cnt_q[i] + CW'(cnt_q[i] != DMAX) : '0;
      lvl[i] = sync_q[i] && cnt_q[i] == DMAX;
    end
  end
  always_ff @(posedge CLK) begin
    if (CLR) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign lvl = sync_q;
`endif
  assign ev = lvl & ~prev_q;
  state_t      state_q, state_d;
  logic        side_q, side_d, loser_q, loser_d;
  logic [7:0]  moves_q, moves_d;
  logic [26:0] presc_q, presc_d;
  logic        run_q, stay, enter;
  always_comb begin
    state_d = state_q;
    side_d = side_q;
    loser_d = loser_q;
    moves_d = moves_q;
    case (state_q)
      IDLE: if (ev[0]) state_d = RUN_A;
      RUN_A:
        if (TIMEOUT_A) begin
          state_d = DONE;
          loser_d = 1'b0;
        end else if (ev[1]) begin
          state_d = PAUSED;
          side_d = 1'b0;
        end else if (ev[2]) begin
          state_d = RUN_B;
          moves_d = moves_q + 8'(moves_q != 8'hff);
        end
      RUN_B:
        if (TIMEOUT_B) begin
          state_d = DONE;
          loser_d = 1'b1;
        end else if (ev[1]) begin
          state_d = PAUSED;
          side_d = 1'b1;
        end else if (ev[3]) begin
          state_d = RUN_A;
          moves_d = moves_q + 8'(moves_q != 8'hff);
        end
      PAUSED: if (ev[1]) state_d = side_q ? RUN_B : RUN_A;
      default: ;
    endcase
    run_q = state_q == RUN_A || state_q == RUN_B;
    stay = run_q && state_d == state_q;
    // resuming from PAUSED keeps the fractional second
    enter = (state_d == RUN_A || state_d == RUN_B) && state_d != state_q && state_q != PAUSED;
    presc_d = stay ? (presc_q == TC ? '0 : presc_q + 27'd1) : enter ? '0 : presc_q;
  end
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      side_q <= 1'b0;
      loser_q <= 1'b0;
      moves_q <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      side_q <= side_d;
      loser_q <= loser_d;
      moves_q <= moves_d;
      presc_q <= presc_d;
    end
  end
  assign CE_A = state_q == RUN_A;
  assign CE_B = state_q == RUN_B;
  assign IMPULSE_A = CE_A && state_d == RUN_A && presc_q == TC;
  assign IMPULSE_B = CE_B && state_d == RUN_B && presc_q == TC;
  assign ACTIVE = {state_q == RUN_B || state_q == PAUSED, state_q == RUN_A || state_q == PAUSED};
  assign GAME_OVER = state_q == DONE;
  assign LOSER = loser_q;
  assign MOVE_CNT = moves_q;
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed self-checking bench for turn_controller with TICK_DIV=4, DEB_CYCLES=5.
module tb_turn_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clr, start, pause, btn_a, btn_b, to_a, to_b;
  logic ce_a, ce_b, imp_a, imp_b, game_over, loser;
  logic [1:0] active;
  logic [7:0] move_cnt;
  int n_tests = 0, n_fail = 0;

  turn_controller #(.TICK_DIV(4), .DEB_CYCLES(5)) dut (
    .CLK(clk), .CLR(clr), .START(start), .PAUSE(pause), .BTN_A(btn_a), .BTN_B(btn_b),
    .TIMEOUT_A(to_a), .TIMEOUT_B(to_b), .CE_A(ce_a), .CE_B(ce_b), .IMPULSE_A(imp_a),
    .IMPULSE_B(imp_b), .ACTIVE(active), .GAME_OVER(game_over), .LOSER(loser), .MOVE_CNT(move_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [1:0] act, input logic ca, input logic cb,
                        input logic ia, input logic ib);
    check({tag, "_active"}, active, act);
    check({tag, "_ce_a"}, ce_a, ca);
    check({tag, "_ce_b"}, ce_b, cb);
    check({tag, "_imp_a"}, imp_a, ia);
    check({tag, "_imp_b"}, imp_b, ib);
  endtask

  task automatic chk_zero(input string tag);
    chk_st(tag, 2'b00, 0, 0, 0, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_loser"}, loser, 0);
    check({tag, "_moves"}, move_cnt, 0);
  endtask

  initial begin
    {clr, start, pause, btn_a, btn_b, to_a, to_b} = 7'b1000000;
    tick;
    tick;
    clr = 1'b0;
    chk_zero("reset");
`ifndef TURN_CONTROLLER_DEBOUNCE_EN
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_lat", active, 0);
    tick;
    chk_st("entry", 2'b01, 1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      tick;
      check("run_a_imp_a", imp_a, i % 4 == 3);
      check("run_a_imp_b", imp_b, 0);
    end
    btn_a = 1'b1;
    tick;
    check("sw_lat", active, 2'b01);
    tick;
    chk_st("sw_b", 2'b10, 0, 1, 0, 0);
    check("moves1", move_cnt, 1);
    for (int j = 1; j <= 8; j++) begin
      tick;
      check("hold_active", active, 2'b10);
      check("run_b_imp_b", imp_b, j % 4 == 3);
      check("run_b_imp_a", imp_a, 0);
    end
    btn_a = 1'b0;
    check("hold_moves", move_cnt, 1);
    tick;
    pause = 1'b1;
    tick;
    check("pause_ev_imp", imp_b, 0);
    pause = 1'b0;
    tick;
    chk_st("paused", 2'b11, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick;
      check("pause_hold_active", active, 2'b11);
      check("pause_hold_imp", {imp_a, imp_b}, 0);
    end
    pause = 1'b1;
    tick;
    pause = 1'b0;
    check("resume_lat", active, 2'b11);
    tick;
    chk_st("resume", 2'b10, 0, 1, 0, 0);
    tick;
    check("resume_frac_imp", imp_b, 1);
    tick;
    check("resume_wrap_imp", imp_b, 0);
    btn_b = 1'b1;
    tick;
    btn_b = 1'b0;
    tick;
    check("back_a_active", active, 2'b01);
    check("moves2", move_cnt, 2);
    tick;
    tick;
    btn_a = 1'b1;
    to_a = 1'b1;
    tick;
    check("to_sup_imp_a", imp_a, 0);
    tick;
    btn_a = 1'b0;
    to_a = 1'b0;
    chk_st("done", 2'b00, 0, 0, 0, 0);
    check("done_game_over", game_over, 1);
    check("done_loser", loser, 0);
    check("done_moves", move_cnt, 2);
    start = 1'b1; tick; tick; start = 1'b0;
    pause = 1'b1; tick; tick; pause = 1'b0;
    btn_a = 1'b1; tick; tick; btn_a = 1'b0;
    btn_b = 1'b1; tick; tick; btn_b = 1'b0;
    tick;
    check("sticky_game_over", game_over, 1);
    check("sticky_active", active, 0);
    check("sticky_moves", move_cnt, 2);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk_zero("clr");
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int m = 1; m <= 300; m++) begin
      if (m % 2 == 1) btn_a = 1'b1;
      else btn_b = 1'b1;
      tick;
      btn_a = 1'b0;
      btn_b = 1'b0;
      tick;
      check("alt_active", active, (m % 2 == 1) ? 2 : 1);
      if (m == 1 || m == 254 || m == 255 || m == 300) check("sat_moves", move_cnt, m > 255 ? 255 : m);
    end
    tick;
    tick;
    btn_a = 1'b1;
    btn_b = 1'b1;
    tick;
    check("sw_sup_imp_a", imp_a, 0);
    btn_a = 1'b0;
    btn_b = 1'b0;
    tick;
    check("ab_active", active, 2'b10);
    check("ab_moves", move_cnt, 255);
    tick;
    tick;
    check("ab_stay", active, 2'b10);
    to_b = 1'b1;
    tick;
    to_b = 1'b0;
    check("to_b_game_over", game_over, 1);
    check("to_b_loser", loser, 1);
    check("to_b_ce_b", ce_b, 0);
    check("to_b_active", active, 0);
`else
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick;
      check("deb_start", active, i == 6 ? 1 : 0);
    end
    start = 1'b0;
    btn_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("glitch_active", active, 2'b01);
    end
    btn_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("glitch_after", active, 2'b01);
    end
    check("glitch_moves", move_cnt, 0);
    btn_a = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick;
      check("deb_press", active, i == 6 ? 2 : 1);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      check("deb_hold", active, 2'b10);
    end
    btn_a = 1'b0;
    check("deb_moves", move_cnt, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
